// File: rtl/reg_cmd_ctrl.sv
// Byte-serial command parser that issues register-file write/read strobes
// and returns one response byte per read to the UART transmit path.
module reg_cmd_ctrl #(
  parameter int               WIDTH      = 8,
  parameter int               ADDR_W     = 4,
  parameter logic [WIDTH-1:0] CMD_WR     = 8'hAA,
  parameter logic [WIDTH-1:0] CMD_RD     = 8'hBB,
  parameter int               RD_TIMEOUT = 4,
  parameter logic [WIDTH-1:0] ERR_BYTE   = 8'hFF
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [WIDTH-1:0]  RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic [WIDTH-1:0]  RdData,
  input  logic              RdData_Valid,
  input  logic              TX_BUSY,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADDR_W-1:0] Address,
  output logic [WIDTH-1:0]  WrData,
  output logic [WIDTH-1:0]  TX_P_DATA,
  output logic              TX_D_VLD,
  output logic              CMD_BUSY
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  // Kept as a named signal so checkers can bind to the parser state.
  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Handshakes: RX_D_VLD is a one-cycle qualifier for RX_P_DATA with no
  // back-pressure (bytes arriving while CMD_BUSY is high are dropped);
  // TX_D_VLD pulses once, only on a cycle where TX_BUSY is sampled low.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CMD_BUSY  <= 1'b0;
    end else begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      TX_D_VLD <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_WR)      state <= WR_ADDR;
            else if (RX_P_DATA == CMD_RD) state <= RD_ADDR;
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            Address <= RX_P_DATA[ADDR_W-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            WrData <= RX_P_DATA;
            WrEn   <= 1'b1;
            state  <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address  <= RX_P_DATA[ADDR_W-1:0];
            RdEn     <= 1'b1;
            wait_cnt <= '0;
            CMD_BUSY <= 1'b1;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Returned data wins over a timeout landing on the same edge.
          if (RdData_Valid) begin
            TX_P_DATA <= RdData;
            state     <= TX_SEND;
          end else if (wait_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            TX_P_DATA <= ERR_BYTE;
            state     <= TX_SEND;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        TX_SEND: begin
          if (!TX_BUSY) begin
            TX_D_VLD <= 1'b1;
            CMD_BUSY <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          CMD_BUSY <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: a small register-file responder, a
// shadow-memory model of expected read data and a per-cycle scoreboard.
module tb_reg_cmd_ctrl;

  localparam int         WIDTH      = 8;
  localparam int         ADDR_W     = 4;
  localparam logic [7:0] CMD_WR     = 8'hAA;
  localparam logic [7:0] CMD_RD     = 8'hBB;
  localparam int         RD_TIMEOUT = 4;
  localparam logic [7:0] ERR_BYTE   = 8'hFF;

  logic              CLK = 1'b0;
  logic              RST_n = 1'b0;
  logic [WIDTH-1:0]  RX_P_DATA = '0;
  logic              RX_D_VLD = 1'b0;
  logic [WIDTH-1:0]  RdData;
  logic              RdData_Valid;
  logic              TX_BUSY = 1'b0;
  logic              WrEn;
  logic              RdEn;
  logic [ADDR_W-1:0] Address;
  logic [WIDTH-1:0]  WrData;
  logic [WIDTH-1:0]  TX_P_DATA;
  logic              TX_D_VLD;
  logic              CMD_BUSY;

  reg_cmd_ctrl #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD),
    .RD_TIMEOUT(RD_TIMEOUT), .ERR_BYTE(ERR_BYTE)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_BUSY(TX_BUSY),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_BUSY(CMD_BUSY)
  );

  // ---------------- clock / cycle count ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- register-file responder ----------------
  // Addresses 2 and 3 hold the UART config defaults and ignore writes.
  logic [7:0] rf_mem [16] = '{8'h00, 8'h00, 8'h81, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic       rf_vld = 1'b0;
  logic [7:0] rf_data = '0;
  bit         rf_respond = 1'b1;

  always @(posedge CLK) begin
    rf_vld  <= RdEn && rf_respond;
    rf_data <= rf_mem[Address];
    if (WrEn && Address != 4'd2 && Address != 4'd3) rf_mem[Address] <= WrData;
  end
  assign RdData       = rf_data;
  assign RdData_Valid = rf_vld;

  // ---------------- scoreboard ----------------
  logic [11:0] exp_wr_q[$];
  int          exp_wr_cyc_q[$];
  logic [3:0]  exp_rd_q[$];
  int          exp_rd_cyc_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_tx_cyc_q[$];
  logic [7:0]  exp_mem [16];
  int          busy_from = 0;
  int          busy_to = 0;
  int          tx_count = 0;
  int          last_tx_cyc = 0;
  int          last_rd_k = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST_n) begin
      check("reset_outputs",
            32'({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_BUSY}), 32'd0);
    end else begin
      check("cmd_busy", 32'(CMD_BUSY), 32'(cyc >= busy_from && cyc < busy_to));
      if (WrEn || RdEn) check("strobe_exclusive", 32'(WrEn && RdEn), 32'd0);
      if (WrEn) begin
        if (exp_wr_q.size() == 0) check("unexpected_wren", 32'(WrEn), 32'd0);
        else begin
          check("wr_addr_data", 32'({Address, WrData}), 32'(exp_wr_q.pop_front()));
          check("wr_cycle", cyc, exp_wr_cyc_q.pop_front());
        end
      end
      if (RdEn) begin
        if (exp_rd_q.size() == 0) check("unexpected_rden", 32'(RdEn), 32'd0);
        else begin
          check("rd_addr", 32'(Address), 32'(exp_rd_q.pop_front()));
          check("rd_cycle", cyc, exp_rd_cyc_q.pop_front());
        end
      end
      if (TX_D_VLD) begin
        tx_count++;
        last_tx_cyc = cyc;
        if (exp_tx_q.size() == 0) check("unexpected_tx_vld", 32'(TX_D_VLD), 32'd0);
        else begin
          check("tx_data", 32'(TX_P_DATA), 32'(exp_tx_q.pop_front()));
          check("tx_cycle", cyc, exp_tx_cyc_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (call on a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(CMD_WR);
    send_byte(a);
    exp_wr_q.push_back({a[3:0], d});
    exp_wr_cyc_q.push_back(cyc + 1);
    if (a[3:0] != 4'd2 && a[3:0] != 4'd3) exp_mem[a[3:0]] = d;
    send_byte(d);
  endtask

  // lat: cycles from the address byte's sampling edge to the response pulse.
  task automatic do_read(input logic [7:0] a, input int lat);
    int k;
    send_byte(CMD_RD);
    k = cyc + 1;
    last_rd_k = k;
    exp_rd_q.push_back(a[3:0]);
    exp_rd_cyc_q.push_back(k);
    exp_tx_q.push_back(rf_respond ? exp_mem[a[3:0]] : ERR_BYTE);
    exp_tx_cyc_q.push_back(k + lat);
    busy_from = k;
    busy_to   = k + lat;
    send_byte(a);
  endtask

  task automatic wait_tx(input string name);
    int start;
    int n;
    start = tx_count;
    n = 0;
    while (tx_count == start && n < 40) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check(name, 32'(tx_count - start), 32'd1);
  endtask

  task automatic pulse_reset(input int n);
    #1 RST_n = 1'b0;
    repeat (n) @(negedge CLK);
    #1 RST_n = 1'b1;
    @(negedge CLK);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    exp_mem[2] = 8'h81;
    exp_mem[3] = 8'h20;

    repeat (3) @(negedge CLK);
    #1 RST_n = 1'b1;
    @(negedge CLK);
    check("post_reset_tx_data", 32'(TX_P_DATA), 32'd0);
    check("post_reset_busy", 32'(CMD_BUSY), 32'd0);

    // write then read back
    do_write(8'h05, 8'h3C);
    do_read(8'h05, 3);
    wait_tx("tx_wr_rd");
    check("pin_rd_data_3c", 32'(TX_P_DATA), 32'h3C);
    check("pin_rd_latency", 32'(last_tx_cyc - last_rd_k), 32'd3);

    // protected register keeps its reset default
    @(negedge CLK);
    pulse_reset(2);
    do_write(8'h02, 8'h55);
    do_read(8'h02, 3);
    wait_tx("tx_protected");
    check("pin_protected_81", 32'(TX_P_DATA), 32'h81);

    // back-pressure for 10 cycles; bytes sent meanwhile are dropped
    TX_BUSY = 1'b1;
    do_read(8'h05, 10);
    send_byte(CMD_WR);
    send_byte(8'h05);
    send_byte(8'h77);
    repeat (6) @(negedge CLK);
    TX_BUSY = 1'b0;
    wait_tx("tx_backpressure");
    check("pin_bp_data_3c", 32'(TX_P_DATA), 32'h3C);
    check("pin_bp_latency", 32'(last_tx_cyc - last_rd_k), 32'd10);
    do_read(8'h05, 3);
    wait_tx("tx_after_drop_busy");

    // unknown opcode ignored; opcode in RD_WAIT dropped
    send_byte(8'h12);
    send_byte(8'h05);
    repeat (3) @(negedge CLK);
    do_read(8'h05, 3);
    send_byte(CMD_WR);
    wait_tx("tx_drop_rdwait");
    do_read(8'h05, 3);
    wait_tx("tx_after_drop_rdwait");

    // timeout with no register-file response
    rf_respond = 1'b0;
    do_read(8'h07, RD_TIMEOUT + 1);
    wait_tx("tx_timeout");
    check("pin_timeout_ff", 32'(TX_P_DATA), 32'hFF);
    check("pin_timeout_latency", 32'(last_tx_cyc - last_rd_k), 32'd5);
    rf_respond = 1'b1;

    // reset aborts a half-received write; trailing data byte is an opcode
    @(negedge CLK);
    send_byte(CMD_WR);
    send_byte(8'h05);
    pulse_reset(3);
    send_byte(8'h3C);
    repeat (4) @(negedge CLK);

    // reset while waiting on read data: no response afterwards
    send_byte(CMD_RD);
    exp_rd_q.push_back(4'd5);
    exp_rd_cyc_q.push_back(cyc + 1);
    busy_from = cyc + 1;
    busy_to   = cyc + 3;
    send_byte(8'h05);
    @(negedge CLK);
    pulse_reset(3);
    repeat (5) @(negedge CLK);

    // upper address bits ignored; back-to-back writes at full byte rate
    do_write(8'h1A, 8'h99);
    do_read(8'h0A, 3);
    wait_tx("tx_upper_addr");
    check("pin_upper_addr_99", 32'(TX_P_DATA), 32'h99);
    do_write(8'h04, 8'h11);
    do_write(8'h04, 8'h22);
    do_read(8'h04, 3);
    wait_tx("tx_back_to_back");

    repeat (5) @(negedge CLK);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
